sar_scan_controller: RTL and testbench
======================================

Name: sar_scan_controller

Overview:
- Parametrised multi-channel successive-approximation conversion controller.
- Built-in programmable clock-enable divider replaces the toggled divided clock. All logic runs on clk, and the divider only qualifies updates.
- Sequences sample/hold, the N_BITS SAR binary search against an external comparator, and round-robin channel scanning.
- Delivers results over a valid/ready port with end-of-conversion and overrun reporting. Sits between the analog front end (DAC, comparator, mux) and the digital consumer.

Parameters:
- N_BITS, 10, conversion resolution in bits (>=2).
- N_CH, 4, number of analog channels (>=1).
- DIV_W, 16, width of the runtime divider value.
- SAMPLE_TICKS, 2, number of divider ticks spent in sample/hold before conversion (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- stop  in  1  pulse; finish the current conversion, then go to IDLE.
- continuous  in  1  latched at start; 1 = scan repeatedly, 0 = single pass over enabled channels.
- div_value  in  DIV_W  ticks every div_value clk cycles; latched at start.
- ch_mask  in  N_CH  enabled channels; latched at start.
- comp_in  in  1  comparator output, 1 = Vin >= DAC code.
- sample_hold  out  1  1 while tracking (SAMPLE state).
- ch_sel  out  $clog2(N_CH) (min 1)  active mux channel.
- dac_code  out  N_BITS  trial code driven to the DAC.
- busy  out  1  state != IDLE.
- eoc  out  1  one-cycle pulse when a conversion completes.
- result_data  out  N_BITS  converted code.
- result_ch  out  $clog2(N_CH) (min 1)  channel of result_data.
- result_valid  out  1  result held until accepted.
- result_ready  in  1  consumer accept.
- overrun  out  1  sticky; set when a result is overwritten unread.

Behaviour:
- Reset values: all outputs 0, state IDLE, tick counter 0, latched configuration 0. overrun clears only on reset.
- Divider:
  - Effective divisor D = max(div_value_latched, 1).
  - The counter restarts at 0 when start is accepted and counts 0..D-1.
  - tick is asserted in the cycle the counter equals D-1, then the counter wraps to 0.
  - D=1 gives a tick every cycle.
  - The counter runs only while busy.
- FSM IDLE:
  - start with ch_mask != 0 latches div_value, ch_mask and continuous.
  - Selects the lowest enabled channel and moves to SAMPLE.
  - start with ch_mask == 0 is ignored.
- FSM SAMPLE:
  - sample_hold = 1 and dac_code = 0.
  - After SAMPLE_TICKS ticks, moves to CONVERT with dac_code = 1 << (N_BITS-1) and bit index = N_BITS-1.
- FSM CONVERT:
  - On each tick, comp_in is sampled.
  - If 0, the current trial bit is cleared. If 1, it is kept.
  - The next lower bit is then set.
  - After the tick for bit 0, the final code is loaded into result_data/result_ch, result_valid = 1 and eoc pulses for one cycle. All of this happens on the same edge.
- Next state after a conversion:
  - stop seen during the conversion (latched flag) -> IDLE.
  - continuous -> SAMPLE on the next enabled channel after ch_sel, wrapping to the lowest enabled channel.
  - single pass -> next higher enabled channel, or IDLE if none remains.
- Latency: with start accepted at cycle 0, eoc is asserted at cycle (SAMPLE_TICKS + N_BITS) * D. Back-to-back conversions in continuous mode are spaced by the same amount.
- Handshake:
  - result_valid falls the cycle after result_valid && result_ready.
  - A new completion while result_valid=1 and no accept in that cycle overwrites the data and sets overrun.
  - A completion in the same cycle as an accept is not an overrun; result_valid stays 1 with the new data.
- stop is ignored in IDLE. Inputs start and div_value are ignored while busy.
- Reset mid-operation aborts immediately with no eoc, and discards any pending result.

Decomposition:
- Shared package sar_scan_pkg:
  - state enum (IDLE, SAMPLE, CONVERT);
  - function next_enabled_ch(mask, cur, wrap) implementing the channel-search rule;
  - localparam CH_W.
- Sub-module tick_divider:
  - parameter DIV_W;
  - ports clk, reset, clear, enable, div_value, tick;
  - the successor of the frequency divider, generating a clock enable instead of a clock.

Test Plan:
- N_BITS=10, D=1, SAMPLE_TICKS=2, single, mask=0b0001, comparator model Vin=0x2A5 -> eoc at cycle 12, result_data=0x2A5, result_ch=0, then busy=0.
- Same with div_value=4 -> eoc at cycle 48, dac_code changes only on tick edges. div_value=0 -> identical to div_value=1.
- continuous=1, mask=0b1010, ready held high -> result_ch sequence 1,3,1,3. Single pass with mask=0b1010 -> exactly two eoc pulses, then IDLE.
- Vin=0x000 and Vin=0x3FF -> results 0x000 and 0x3FF.
- Continuous, result_ready=0 for two conversions -> overrun=1, result_data holds the second code. Accept in the completion cycle -> overrun stays 0.
- Reset asserted mid-CONVERT -> the next cycle shows all outputs 0 and no eoc. stop mid-CONVERT in continuous mode -> that conversion completes with eoc, then IDLE. start with mask=0 -> busy stays 0.

Source files
------------

// File: rtl/sar_scan_pkg.sv
// Shared types and helpers for the SAR scan controller.
//   state_e          : controller FSM states
//   MAX_CH           : upper bound on channel count the search helper handles
//   ch_width()       : channel-select width for a given channel count (min 1)
//   CH_W             : channel-select width for the default channel count
//   next_enabled_ch(): round-robin channel search, returns -1 when none found
package sar_scan_pkg;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_e;

  localparam int MAX_CH   = 32;
  localparam int N_CH_DEF = 4;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_width(N_CH_DEF);

  // Lowest enabled channel strictly above cur; if none and wrap is set, the
  // lowest enabled channel at or below cur (so a single enabled channel maps
  // to itself). cur = -1 yields the lowest enabled channel overall.
  function automatic int next_enabled_ch(input logic [MAX_CH-1:0] mask,
                                         input int cur, input logic wrap);
    int hi, lo;
    hi = -1;
    lo = -1;
    // Descending scan so the last hit in each half is the smallest index.
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        if (i > cur) hi = i;
        else         lo = i;
      end
    end
    if (hi >= 0) return hi;
    return wrap ? lo : -1;
  endfunction

endpackage

// File: rtl/sar_scan_controller_tick_divider.sv
// Programmable clock-enable generator.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the count at 0 (takes priority over enable)
//   enable     : counter advances only while set
//   div_value  : divisor, 0 is treated as 1
//   tick       : high in the cycle the count reaches divisor-1
module tick_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_value,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] last;

  assign last = (div_value == '0) ? '0 : div_value - 1'b1;
  assign tick = enable && !clear && (cnt_q == last);

  always_ff @(posedge clk) begin
    if (reset || clear) cnt_q <= '0;
    else if (enable)    cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/sar_scan_controller.sv
// Multi-channel SAR conversion controller with clock-enable divider,
// round-robin channel scan and valid/ready result port.
//   clk, reset          : system clock, synchronous active-high reset
//   start_i, stop_i     : begin scan (IDLE only) / finish current conversion
//   continuous_i        : repeat scan vs single pass (latched at start)
//   div_value_i         : tick divisor (latched at start)
//   ch_mask_i           : enabled channels (latched at start)
//   comp_in_i           : comparator, 1 = Vin >= dac_code
//   sample_hold_o, ch_sel_o, dac_code_o : analog front-end controls
//   busy_o, eoc_o       : activity and end-of-conversion pulse
//   result_*            : result port, held until result_ready_i
//   overrun_o           : sticky, a result was overwritten unread
module sar_scan_controller
  import sar_scan_pkg::*;
#(
  parameter int N_BITS       = 10,
  parameter int N_CH         = N_CH_DEF,
  parameter int DIV_W        = 16,
  parameter int SAMPLE_TICKS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic                        continuous_i,
  input  logic [DIV_W-1:0]            div_value_i,
  input  logic [N_CH-1:0]             ch_mask_i,
  input  logic                        comp_in_i,
  output logic                        sample_hold_o,
  output logic [ch_width(N_CH)-1:0]   ch_sel_o,
  output logic [N_BITS-1:0]           dac_code_o,
  output logic                        busy_o,
  output logic                        eoc_o,
  output logic [N_BITS-1:0]           result_data_o,
  output logic [ch_width(N_CH)-1:0]   result_ch_o,
  output logic                        result_valid_o,
  input  logic                        result_ready_i,
  output logic                        overrun_o
);

  localparam int CHW = ch_width(N_CH);
  localparam int STW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
  localparam int BW  = $clog2(N_BITS);

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [N_CH-1:0]   mask_q;
  logic              cont_q, stop_q;
  logic [CHW-1:0]    ch_q;
  logic [N_BITS-1:0] dac_q;
  logic [BW-1:0]     bit_q;
  logic [STW-1:0]    samp_q;
  logic              eoc_q, rvalid_q, overrun_q;
  logic [N_BITS-1:0] rdata_q;
  logic [CHW-1:0]    rch_q;

  logic              busy, tick, start_acc, stop_now;
  logic [N_BITS-1:0] bit_mask, code_d;
  int                first_ch, wrap_ch, fwd_ch;

  assign busy      = (state_q != IDLE);
  assign start_acc = (state_q == IDLE) && start_i && (ch_mask_i != '0);
  assign stop_now  = stop_q || stop_i;

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_acc),
    .enable    (busy),
    .div_value (div_q),
    .tick      (tick)
  );

  always_comb begin
    bit_mask = N_BITS'(1) << bit_q;
    // Keep or drop the trial bit, then try the next lower one. For bit 0 the
    // shifted mask is empty, so code_d is the final result.
    code_d   = (comp_in_i ? dac_q : (dac_q & ~bit_mask)) | (bit_mask >> 1);
    first_ch = next_enabled_ch(MAX_CH'(ch_mask_i), -1, 1'b0);
    wrap_ch  = next_enabled_ch(MAX_CH'(mask_q), int'(ch_q), 1'b1);
    fwd_ch   = next_enabled_ch(MAX_CH'(mask_q), int'(ch_q), 1'b0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      mask_q    <= '0;
      cont_q    <= 1'b0;
      stop_q    <= 1'b0;
      ch_q      <= '0;
      dac_q     <= '0;
      bit_q     <= '0;
      samp_q    <= '0;
      eoc_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rch_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      eoc_q <= 1'b0;
      if (rvalid_q && result_ready_i) rvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (start_acc) begin
          div_q   <= div_value_i;
          mask_q  <= ch_mask_i;
          cont_q  <= continuous_i;
          stop_q  <= 1'b0;
          ch_q    <= CHW'(first_ch);
          samp_q  <= '0;
          dac_q   <= '0;
          state_q <= SAMPLE;
        end
        SAMPLE: begin
          if (stop_i) stop_q <= 1'b1;
          if (tick) begin
            if (samp_q == STW'(SAMPLE_TICKS - 1)) begin
              samp_q  <= '0;
              dac_q   <= N_BITS'(1) << (N_BITS - 1);
              bit_q   <= BW'(N_BITS - 1);
              state_q <= CONVERT;
            end else begin
              samp_q <= samp_q + 1'b1;
            end
          end
        end
        CONVERT: begin
          if (stop_i) stop_q <= 1'b1;
          if (tick) begin
            dac_q <= code_d;
            bit_q <= bit_q - 1'b1;
            if (bit_q == '0) begin
              eoc_q    <= 1'b1;
              rdata_q  <= code_d;
              rch_q    <= ch_q;
              // Overrides the accept-clear above: a completion coinciding
              // with an accept leaves valid high with fresh data.
              rvalid_q <= 1'b1;
              if (rvalid_q && !result_ready_i) overrun_q <= 1'b1;
              dac_q    <= '0;
              stop_q   <= 1'b0;
              if (stop_now) begin
                state_q <= IDLE;
              end else if (cont_q) begin
                ch_q    <= CHW'(wrap_ch);
                state_q <= SAMPLE;
              end else if (fwd_ch >= 0) begin
                ch_q    <= CHW'(fwd_ch);
                state_q <= SAMPLE;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_hold_o  = (state_q == SAMPLE);
  assign busy_o         = busy;
  assign ch_sel_o       = ch_q;
  assign dac_code_o     = dac_q;
  assign eoc_o          = eoc_q;
  assign result_data_o  = rdata_q;
  assign result_ch_o    = rch_q;
  assign result_valid_o = rvalid_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_sar_scan_controller.sv
module tb_sar_scan_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [15:0] div_value = '0;
  logic [3:0]  ch_mask = '0;
  logic        comp_in;
  logic        sample_hold, busy, eoc, result_valid, overrun;
  logic        result_ready = 1'b1;
  logic [1:0]  ch_sel, result_ch;
  logic [9:0]  dac_code, result_data;
  logic [9:0]  vin = '0;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  typedef struct {
    logic [9:0] data;
    logic [1:0] ch;
    int         at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  sar_scan_controller dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .stop_i         (stop),
    .continuous_i   (continuous),
    .div_value_i    (div_value),
    .ch_mask_i      (ch_mask),
    .comp_in_i      (comp_in),
    .sample_hold_o  (sample_hold),
    .ch_sel_o       (ch_sel),
    .dac_code_o     (dac_code),
    .busy_o         (busy),
    .eoc_o          (eoc),
    .result_data_o  (result_data),
    .result_ch_o    (result_ch),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .overrun_o      (overrun)
  );

  // Ideal comparator against the bench's analog input.
  assign comp_in = (vin >= dac_code);

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  // Monitor: every eoc pops one expected result and checks data, channel, edge.
  always @(negedge clk) begin
    if (!reset && eoc) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL eoc_unexpected edge=%0d data=%h ch=%0d", edges, result_data, result_ch);
      end else begin
        mon_e = sbq.pop_front();
        if (result_data !== mon_e.data || result_ch !== mon_e.ch || edges != mon_e.at) begin
          errors++;
          $display("FAIL eoc_result got data=%h ch=%0d edge=%0d want data=%h ch=%0d edge=%0d",
                   result_data, result_ch, edges, mon_e.data, mon_e.ch, mon_e.at);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog edge=%0d", edges);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_edge(input int e);
    while (edges < e) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_scan(input logic [3:0] m, input logic cont, input logic [15:0] d,
                            output int st);
    ch_mask = m; continuous = cont; div_value = d; start = 1'b1;
    @(negedge clk);
    st = edges;
    start = 1'b0;
  endtask

  task automatic push(input logic [9:0] data, input logic [1:0] ch, input int at);
    exp_t e;
    e.data = data; e.ch = ch; e.at = at;
    sbq.push_back(e);
  endtask

  // Wait for busy to drop; optionally check dac_code only moves on tick edges.
  task automatic run_until_idle(input string name, input int d, input int st,
                                input bit chk_dac, input int budget);
    logic [9:0] prev;
    int n;
    prev = dac_code;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
      if (chk_dac && dac_code !== prev) begin
        checks++;
        if ((edges - st) % d != 0) begin
          errors++;
          $display("FAIL %s_dac_off_tick edge_offset=%0d divisor=%0d", name, edges - st, d);
        end
        prev = dac_code;
      end
    end
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {sample_hold, ch_sel, dac_code, busy, eoc, result_data, result_ch, result_valid, overrun},
        32'd0);

    // Empty mask is ignored.
    start_scan(4'b0000, 1'b0, 16'd1, s);
    chk("mask0_busy_now", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("mask0_busy_later", 32'(busy), 32'd0);

    // D=1, single channel 0.
    vin = 10'h2A5;
    start_scan(4'b0001, 1'b0, 16'd1, s);
    push(10'h2A5, 2'd0, s + 12);
    chk("d1_sample_hold", {sample_hold, busy, dac_code}, {1'b1, 1'b1, 10'h000});
    run_until_idle("d1", 1, s, 1'b0, 40);

    // D=4: latency scales and dac moves only on ticks.
    start_scan(4'b0001, 1'b0, 16'd4, s);
    push(10'h2A5, 2'd0, s + 48);
    run_until_idle("d4", 4, s, 1'b1, 80);

    // D=0 behaves as D=1.
    start_scan(4'b0001, 1'b0, 16'd0, s);
    push(10'h2A5, 2'd0, s + 12);
    run_until_idle("d0", 1, s, 1'b0, 40);

    // Code extremes on channel 2.
    vin = 10'h000;
    start_scan(4'b0100, 1'b0, 16'd1, s);
    push(10'h000, 2'd2, s + 12);
    run_until_idle("vmin", 1, s, 1'b0, 40);
    vin = 10'h3FF;
    start_scan(4'b0100, 1'b0, 16'd1, s);
    push(10'h3FF, 2'd2, s + 12);
    run_until_idle("vmax", 1, s, 1'b0, 40);

    // Reset during CONVERT aborts with no eoc and clears the held result.
    vin = 10'h123;
    start_scan(4'b0100, 1'b0, 16'd1, s);
    wait_edge(s + 6);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs",
        {sample_hold, ch_sel, dac_code, busy, eoc, result_data, result_ch, result_valid, overrun},
        32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_stays_idle", {busy, eoc}, 32'd0);

    // Single pass over channels 1 and 3.
    vin = 10'h155;
    start_scan(4'b1010, 1'b0, 16'd1, s);
    push(10'h155, 2'd1, s + 12);
    push(10'h155, 2'd3, s + 24);
    run_until_idle("single2", 1, s, 1'b0, 60);

    // Continuous 1,3,1,3 then stop mid-CONVERT of the fourth conversion.
    vin = 10'h2C3;
    start_scan(4'b1010, 1'b1, 16'd1, s);
    push(10'h2C3, 2'd1, s + 12);
    push(10'h2C3, 2'd3, s + 24);
    push(10'h2C3, 2'd1, s + 36);
    push(10'h2C3, 2'd3, s + 48);
    wait_edge(s + 40);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    run_until_idle("cont_stop", 1, s, 1'b0, 40);
    repeat (20) @(negedge clk);
    chk("cont_stop_queue", 32'(sbq.size()), 32'd0);

    // Two unread completions -> overrun, second code held.
    do_reset();
    result_ready = 1'b0;
    vin = 10'h100;
    start_scan(4'b0001, 1'b1, 16'd1, s);
    push(10'h100, 2'd0, s + 12);
    push(10'h0AB, 2'd0, s + 24);
    wait_edge(s + 13);
    chk("ovr_after_first", {overrun, result_valid}, {30'd0, 1'b0, 1'b1});
    vin = 10'h0AB;
    wait_edge(s + 16);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_edge(s + 25);
    chk("ovr_set", {overrun, result_valid, busy, result_data},
        {19'd0, 1'b1, 1'b1, 1'b0, 10'h0AB});
    result_ready = 1'b1;
    @(negedge clk);
    chk("ovr_accept", {overrun, result_valid}, {30'd0, 1'b1, 1'b0});

    // Accept coinciding with completion is not an overrun.
    do_reset();
    result_ready = 1'b0;
    vin = 10'h1F0;
    start_scan(4'b0001, 1'b1, 16'd1, s);
    push(10'h1F0, 2'd0, s + 12);
    push(10'h0F1, 2'd0, s + 24);
    wait_edge(s + 13);
    vin = 10'h0F1;
    wait_edge(s + 16);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_edge(s + 23);
    chk("coinc_pre_valid", 32'(result_valid), 32'd1);
    result_ready = 1'b1;
    wait_edge(s + 24);
    chk("coinc_no_ovr", {overrun, result_valid, result_data},
        {20'd0, 1'b0, 1'b1, 10'h0F1});
    wait_edge(s + 25);
    chk("coinc_drop_valid", {result_valid, busy}, 32'd0);

    repeat (5) @(negedge clk);
    chk("final_queue_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
